// File: rtl/alu_link_arbiter.sv
// Round-robin arbiter that shares one serial mtm_Alu link (sin/sout) among N_REQ clients.
// Define ALU_TIMEOUT_EN to give up on a silent ALU after TIMEOUT cycles in WAIT_RSP.
module alu_link_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [32*N_REQ-1:0] req_a,
  input  logic [32*N_REQ-1:0] req_b,
  input  logic [3*N_REQ-1:0]  req_op,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [31:0]         rsp_data,
  output logic [3:0]          rsp_flags,
  output logic                rsp_err,
  output logic [5:0]          rsp_err_flags,
  output logic                sin,
  input  logic                sout
);
  localparam int PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PKT_BITS = 99;
  localparam int RSP_BITS = 55;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARB      = 3'd1,
    SEND     = 3'd2,
    WAIT_RSP = 3'd3,
    RECV     = 3'd4,
    DONE     = 3'd5
  } state_t;

  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  function automatic logic [2:0] crc3(input logic [35:0] d);
    logic [2:0] c;
    logic       fb;
    c = 3'd0;
    for (int i = 35; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return c;
  endfunction

  function automatic logic [10:0] frame(input logic ftype, input logic [7:0] payload);
    return {1'b0, ftype, payload, 1'b1};
  endfunction

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [PKT_BITS-1:0]   pkt_q, pkt_d;
  logic [RSP_BITS-1:0]   rx_q, rx_d;
  logic [6:0]            bcnt_q, bcnt_d;
  logic                  sin_q, sin_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic [3:0]            rsp_flags_q, rsp_flags_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [5:0]            rsp_err_flags_q, rsp_err_flags_d;
`ifdef ALU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
`endif

  logic                  arb_found;
  logic [PW-1:0]         arb_win;
  logic [PW-1:0]         cand;
  logic [PW-1:0]         next_ptr;
  logic [N_REQ-1:0]      win_oh;
  logic [N_REQ-1:0]      owner_oh;
  logic [31:0]           sel_a;
  logic [31:0]           sel_b;
  logic [2:0]            sel_op;
  logic [PKT_BITS-1:0]   pkt_new;
  logic [RSP_BITS-1:0]   rx_next;
  logic [31:0]           rx_c;
  logic [3:0]            rx_flags;
  logic                  rx_stops_ok;

  // Round-robin search from the pointer, wrapping, plus operand selection for the winner.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % N_REQ);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_win   = cand;
      end else begin
        arb_found = arb_found;
      end
    end
    sel_a  = 32'd0;
    sel_b  = 32'd0;
    sel_op = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      win_oh[i]   = (PW'(i) == arb_win);
      owner_oh[i] = (PW'(i) == owner_q);
      if (PW'(i) == arb_win) begin
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
        sel_op = req_op[3*i +: 3];
      end else begin
        sel_a  = sel_a;
      end
    end
  end

  assign next_ptr = (arb_win == PW'(N_REQ - 1)) ? '0 : arb_win + 1'b1;

  assign pkt_new = {frame(1'b0, sel_b[31:24]), frame(1'b0, sel_b[23:16]),
                    frame(1'b0, sel_b[15:8]),  frame(1'b0, sel_b[7:0]),
                    frame(1'b0, sel_a[31:24]), frame(1'b0, sel_a[23:16]),
                    frame(1'b0, sel_a[15:8]),  frame(1'b0, sel_a[7:0]),
                    frame(1'b1, {1'b0, sel_op, crc4({sel_b, sel_a, 1'b1, sel_op})})};

  // rx_next holds the response as it will look once this cycle's sout bit is shifted in.
  assign rx_next     = {rx_q[RSP_BITS-2:0], sout};
  assign rx_c        = {rx_next[52:45], rx_next[41:34], rx_next[30:23], rx_next[19:12]};
  assign rx_flags    = rx_next[7:4];
  assign rx_stops_ok = rx_next[44] & rx_next[33] & rx_next[22] & rx_next[11] & rx_next[0];

  // Next-state and output logic of the transaction FSM.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    owner_d         = owner_q;
    pkt_d           = pkt_q;
    rx_d            = rx_q;
    bcnt_d          = bcnt_q;
    sin_d           = 1'b1;
    gnt_d           = '0;
    rsp_valid_d     = '0;
    rsp_data_d      = rsp_data_q;
    rsp_flags_d     = rsp_flags_q;
    rsp_err_d       = rsp_err_q;
    rsp_err_flags_d = rsp_err_flags_q;
`ifdef ALU_TIMEOUT_EN
    to_cnt_d        = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) state_d = ARB;
        else      state_d = IDLE;
      end
      ARB: begin
        if (arb_found) begin
          gnt_d   = win_oh;
          owner_d = arb_win;
          ptr_d   = next_ptr;
          pkt_d   = pkt_new;
          bcnt_d  = 7'd0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        sin_d  = pkt_q[PKT_BITS-1];
        pkt_d  = {pkt_q[PKT_BITS-2:0], 1'b1};
        bcnt_d = bcnt_q + 7'd1;
        if (bcnt_q == 7'd98) state_d = WAIT_RSP;
        else                 state_d = SEND;
      end
      WAIT_RSP: begin
        if (!sout) begin
          rx_d    = '0;
          bcnt_d  = 7'd1;
          state_d = RECV;
        end
`ifdef ALU_TIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          rsp_valid_d     = owner_oh;
          rsp_data_d      = 32'd0;
          rsp_flags_d     = 4'd0;
          rsp_err_d       = 1'b1;
          rsp_err_flags_d = 6'b111111;
          state_d         = DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`else
        else begin
          state_d = WAIT_RSP;
        end
`endif
      end
      RECV: begin
        rx_d   = rx_next;
        bcnt_d = bcnt_q + 7'd1;
        if (bcnt_q == 7'd10 && rx_next[9]) begin
          // First frame typed as control: this is an ALU error frame.
          rsp_valid_d     = owner_oh;
          rsp_data_d      = 32'd0;
          rsp_flags_d     = 4'd0;
          rsp_err_d       = 1'b1;
          rsp_err_flags_d = rx_next[7:2];
          state_d         = DONE;
        end else if (bcnt_q == 7'd54) begin
          rsp_valid_d     = owner_oh;
          rsp_data_d      = rx_c;
          rsp_flags_d     = rx_flags;
          rsp_err_d       = (crc3({rx_c, rx_flags}) != rx_next[3:1]) | ~rx_stops_ok;
          rsp_err_flags_d = 6'd0;
          state_d         = DONE;
        end else begin
          state_d = RECV;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any packet in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      owner_q         <= '0;
      pkt_q           <= '0;
      rx_q            <= '0;
      bcnt_q          <= 7'd0;
      sin_q           <= 1'b1;
      gnt_q           <= '0;
      rsp_valid_q     <= '0;
      rsp_data_q      <= 32'd0;
      rsp_flags_q     <= 4'd0;
      rsp_err_q       <= 1'b0;
      rsp_err_flags_q <= 6'd0;
`ifdef ALU_TIMEOUT_EN
      to_cnt_q        <= '0;
`endif
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      owner_q         <= owner_d;
      pkt_q           <= pkt_d;
      rx_q            <= rx_d;
      bcnt_q          <= bcnt_d;
      sin_q           <= sin_d;
      gnt_q           <= gnt_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_flags_q     <= rsp_flags_d;
      rsp_err_q       <= rsp_err_d;
      rsp_err_flags_q <= rsp_err_flags_d;
`ifdef ALU_TIMEOUT_EN
      to_cnt_q        <= to_cnt_d;
`endif
    end
  end

  assign gnt           = gnt_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_flags     = rsp_flags_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_err_flags = rsp_err_flags_q;
  assign sin           = sin_q;

endmodule

// File: tb/tb_alu_link_arbiter.sv
// Directed bench for alu_link_arbiter: a behavioural mtm_Alu answers on sout,
// expected responses go through a scoreboard queue.
module tb_alu_link_arbiter;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_op;
  logic [1:0]  gnt;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [5:0]  rsp_err_flags;
  logic        sin;
  logic        sout;

  alu_link_arbiter #(.N_REQ(2), .TIMEOUT(256)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .rsp_err_flags(rsp_err_flags), .sin(sin), .sout(sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  oh;
    logic [31:0] data;
    logic [3:0]  flags;
    logic        err;
    logic [5:0]  ef;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // behavioural ALU state
  logic        tx_q[$];
  logic        m_busy;
  int          m_cnt;
  logic [98:0] m_pkt;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic        m_crc_ok, m_frame_ok;
  logic        corrupt_crc;
  logic        silent;

  function automatic logic [3:0] crc4_ref(input logic [67:0] d);
    logic [71:0] r;
    r = {d, 4'b0000};
    for (int i = 71; i >= 4; i--) if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [2:0] crc3_ref(input logic [35:0] d);
    logic [38:0] r;
    r = {d, 3'b000};
    for (int i = 38; i >= 3; i--) if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  task automatic push_frame(input logic t, input logic [7:0] p);
    tx_q.push_back(1'b0);
    tx_q.push_back(t);
    for (int i = 7; i >= 0; i--) tx_q.push_back(p[i]);
    tx_q.push_back(1'b1);
  endtask

  task automatic alu_respond();
    logic [10:0] f;
    logic [7:0]  p [9];
    logic        ok;
    logic        want_t;
    logic [32:0] s;
    logic [31:0] c;
    logic [3:0]  fl;
    logic [5:0]  e;
    logic [2:0]  cc;
    ok = 1'b1;
    for (int k = 0; k < 9; k++) begin
      f      = m_pkt[98-11*k -: 11];
      want_t = (k == 8);
      if (f[10] !== 1'b0 || f[0] !== 1'b1 || f[9] !== want_t) ok = 1'b0;
      p[k] = f[8:1];
    end
    m_b        = {p[0], p[1], p[2], p[3]};
    m_a        = {p[4], p[5], p[6], p[7]};
    m_op       = p[8][6:4];
    m_crc_ok   = (crc4_ref({m_b, m_a, 1'b1, m_op}) === p[8][3:0]);
    m_frame_ok = ok;
    if (silent) return;
    tx_q.push_back(1'b1);
    tx_q.push_back(1'b1);
    e = 6'd0;
    if (!ok || !m_crc_ok) e = 6'b010010;
    else if (!(m_op inside {OP_AND, OP_OR, OP_ADD, OP_SUB})) e = 6'b001001;
    if (e != 6'd0) begin
      push_frame(1'b1, {1'b1, e, ^{1'b1, e}});
    end else begin
      s = 33'd0;
      case (m_op)
        OP_AND:  s = {1'b0, m_a & m_b};
        OP_OR:   s = {1'b0, m_a | m_b};
        OP_ADD:  s = {1'b0, m_a} + {1'b0, m_b};
        default: s = {(m_a < m_b), m_a - m_b};
      endcase
      c = s[31:0];
      fl[3] = s[32];
      if (m_op == OP_ADD)      fl[2] = (m_a[31] == m_b[31]) && (c[31] != m_a[31]);
      else if (m_op == OP_SUB) fl[2] = (m_a[31] != m_b[31]) && (c[31] != m_a[31]);
      else                     fl[2] = 1'b0;
      fl[1] = (c == 32'd0);
      fl[0] = c[31];
      cc = crc3_ref({c, fl});
      if (corrupt_crc) cc[0] = ~cc[0];
      push_frame(1'b0, c[31:24]);
      push_frame(1'b0, c[23:16]);
      push_frame(1'b0, c[15:8]);
      push_frame(1'b0, c[7:0]);
      push_frame(1'b1, {1'b0, fl, cc});
    end
  endtask

  // ALU model: samples sin and drives sout on the falling edge
  initial begin
    sout = 1'b1;
    m_busy = 1'b0;
    m_cnt = 0;
    m_pkt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 1'b0;
        m_cnt  = 0;
        tx_q.delete();
        sout   = 1'b1;
      end else begin
        if (!m_busy) begin
          if (sin === 1'b0) begin
            m_busy = 1'b1;
            m_pkt  = '0;
            m_cnt  = 1;
          end
        end else begin
          m_pkt = {m_pkt[97:0], sin};
          m_cnt++;
          if (m_cnt == 99) begin
            m_busy = 1'b0;
            alu_respond();
          end
        end
        if (tx_q.size() > 0) sout = tx_q.pop_front();
        else                 sout = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[3*i +: 3]  = op;
  endtask

  task automatic push_exp(input logic [1:0] oh, input logic [31:0] d, input logic [3:0] fl,
                          input logic err, input logic [5:0] ef);
    exp_t e;
    e.oh = oh; e.data = d; e.flags = fl; e.err = err; e.ef = ef;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input string tag, input logic [1:0] exp);
    int n;
    n = 0;
    while (gnt === 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_gnt"}, gnt, exp);
  endtask

  task automatic wait_rsp(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (rsp_valid === 2'b00 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_sb: observed a response, expected none queued", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, rsp_valid, e.oh);
      chk({tag, "_data"}, rsp_data, e.data);
      chk({tag, "_flags"}, rsp_flags, e.flags);
      chk({tag, "_err"}, rsp_err, e.err);
      chk({tag, "_errflags"}, rsp_err_flags, e.ef);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, rsp_valid, 2'b00);
  endtask

  task automatic one_txn(input string tag, input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] d, input logic [3:0] fl,
                         input logic err, input logic [5:0] ef);
    logic [1:0] oh;
    oh = (i == 0) ? 2'b01 : 2'b10;
    drive(i, a, b, op);
    push_exp(oh, d, fl, err, ef);
    req[i] = 1'b1;
    wait_gnt(tag, oh);
    req = 2'b00;
    wait_rsp(tag);
    chk({tag, "_alu_a"}, m_a, a);
    chk({tag, "_alu_b"}, m_b, b);
    chk({tag, "_alu_op"}, m_op, op);
    chk({tag, "_alu_crc4"}, m_crc_ok, 1'b1);
    chk({tag, "_alu_frames"}, m_frame_ok, 1'b1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    req = 2'b00;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    corrupt_crc = 1'b0;
    silent = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sin", sin, 1'b1);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_valid", rsp_valid, 2'b00);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_flags", rsp_flags, 4'd0);
    chk("rst_err", rsp_err, 1'b0);
    chk("rst_errflags", rsp_err_flags, 6'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    one_txn("t1_and", 0, 32'hFFFF0000, 32'h0F0F0F0F, OP_AND, 32'h0F0F0000, 4'b0000, 1'b0, 6'd0);
    one_txn("t2_add", 1, 32'h00000001, 32'hFFFFFFFF, OP_ADD, 32'h00000000, 4'b1010, 1'b0, 6'd0);

    // both requesters held: expect grant order 0,1,0
    drive(0, 32'h00000003, 32'h00000005, OP_OR);
    drive(1, 32'h80000000, 32'h00000001, OP_SUB);
    push_exp(2'b01, 32'h00000007, 4'b0000, 1'b0, 6'd0);
    push_exp(2'b10, 32'h7FFFFFFF, 4'b0100, 1'b0, 6'd0);
    push_exp(2'b01, 32'h00000007, 4'b0000, 1'b0, 6'd0);
    req = 2'b11;
    wait_gnt("t3_0", 2'b01);
    wait_rsp("t3_0");
    wait_gnt("t3_1", 2'b10);
    wait_rsp("t3_1");
    wait_gnt("t3_2", 2'b01);
    req = 2'b00;
    wait_rsp("t3_2");

    one_txn("t4_badop", 0, 32'h00000001, 32'h00000002, 3'b111, 32'h0, 4'b0000, 1'b1, 6'b001001);

    corrupt_crc = 1'b1;
    one_txn("t5_crc3", 1, 32'h12345678, 32'h0000000F, OP_OR, 32'h1234567F, 4'b0000, 1'b1, 6'd0);
    corrupt_crc = 1'b0;

    // reset in the middle of SEND abandons the packet
    drive(0, 32'hAAAA5555, 32'h12345678, OP_AND);
    req[0] = 1'b1;
    wait_gnt("t6_pre", 2'b01);
    req = 2'b00;
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_sin", sin, 1'b1);
    chk("t6_rst_data", rsp_data, 32'd0);
    chk("t6_rst_err", rsp_err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) cnt++;
    end
    chk("t6_no_rsp", cnt, 0);
    one_txn("t6_after", 0, 32'hF0F0F0F0, 32'hFF00FF00, OP_AND, 32'hF000F000, 4'b0001, 1'b0, 6'd0);

`ifdef ALU_TIMEOUT_EN
    silent = 1'b1;
    one_txn("t7_timeout", 1, 32'h00000005, 32'h00000006, OP_ADD, 32'h0, 4'b0000, 1'b1, 6'b111111);
    silent = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
